// File: rtl/flash_pkg.sv
// Shared types and constants for the flash playback reader.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FIRST,
    SECOND
  } flash_state_e;

  localparam int unsigned FLASH_ADDR_W     = 23;
  localparam logic [3:0]  FLASH_BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/flash_addr_step.sv
// Next word address inside the playback window, wrapping at either end.
module flash_addr_step
  import flash_pkg::*;
#(
  parameter int unsigned       ADDR_W     = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = '1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              direction_i,
  output logic [ADDR_W-1:0] next_o
);

  // forward steps up and wraps END->START, reverse steps down and wraps START->END
  always_comb begin
    next_o = addr_i;
    if (direction_i) begin
      next_o = (addr_i == START_ADDR) ? END_ADDR : addr_i - 1'b1;
    end else begin
      next_o = (addr_i == END_ADDR) ? START_ADDR : addr_i + 1'b1;
    end
  end

endmodule

// File: rtl/flash_read_sequencer.sv
// Avalon-MM flash word reader that splits each word into two signed
// 16-bit samples and hands one out per consumer strobe.
module flash_read_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned       ADDR_W     = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(23'h07FFFF),
  parameter int unsigned       UNDERRUN_W = 8
) (
  input  logic                  reader_clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  direction,
  input  logic                  restart,
  input  logic                  sample_req,
  input  logic                  flash_mem_waitrequest,
  input  logic                  flash_mem_readdatavalid,
  input  logic [31:0]           flash_mem_readdata,
  output logic                  flash_mem_read,
  output logic [ADDR_W-1:0]     flash_mem_address,
  output logic [3:0]            flash_mem_byteenable,
  output logic [15:0]           sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  flash_state_e          state_q;
  logic                  read_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [31:0]           word_q;
  logic                  rev_order_q;
  logic [15:0]           sample_q;
  logic                  valid_q;
  logic [UNDERRUN_W-1:0] underrun_q;
  logic                  restart_pending_q;

  logic [ADDR_W-1:0]     addr_step_d;
  logic [ADDR_W-1:0]     restart_addr_d;
  logic                  starved_d;

  flash_addr_step #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr_step (
    .addr_i      (addr_q),
    .direction_i (direction),
    .next_o      (addr_step_d)
  );

  assign restart_addr_d = direction ? END_ADDR : START_ADDR;

  // a request is starved when no buffered sample exists; restart takes priority
  always_comb begin
    starved_d = 1'b0;
    if (sample_req && !restart) begin
      case (state_q)
        IDLE:      starved_d = play;
        REQ, WAIT: starved_d = 1'b1;
        default:   starved_d = 1'b0;
      endcase
    end
  end

  // playback FSM with registered Avalon command and sample outputs
  always_ff @(posedge reader_clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      read_q            <= 1'b0;
      addr_q            <= START_ADDR;
      word_q            <= '0;
      rev_order_q       <= 1'b0;
      sample_q          <= '0;
      valid_q           <= 1'b0;
      underrun_q        <= '0;
      restart_pending_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (starved_d && (underrun_q != '1)) begin
        underrun_q <= underrun_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (restart) begin
            addr_q  <= restart_addr_d;
            word_q  <= '0;
            read_q  <= 1'b1;
            state_q <= REQ;
          end else if (play) begin
            read_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (restart) begin
            restart_pending_q <= 1'b1;
          end
          if (!flash_mem_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // a restart seen in the same cycle as the data still discards it
          if (flash_mem_readdatavalid) begin
            if (restart_pending_q || restart) begin
              restart_pending_q <= 1'b0;
              addr_q            <= restart_addr_d;
              read_q            <= 1'b1;
              state_q           <= REQ;
            end else begin
              word_q      <= flash_mem_readdata;
              rev_order_q <= direction;
              state_q     <= FIRST;
            end
          end else if (restart) begin
            restart_pending_q <= 1'b1;
          end
        end
        FIRST: begin
          if (restart) begin
            addr_q  <= restart_addr_d;
            word_q  <= '0;
            read_q  <= 1'b1;
            state_q <= REQ;
          end else if (sample_req) begin
            sample_q <= rev_order_q ? word_q[31:16] : word_q[15:0];
            valid_q  <= 1'b1;
            state_q  <= SECOND;
          end
        end
        SECOND: begin
          if (restart) begin
            addr_q  <= restart_addr_d;
            word_q  <= '0;
            read_q  <= 1'b1;
            state_q <= REQ;
          end else if (sample_req) begin
            sample_q <= rev_order_q ? word_q[15:0] : word_q[31:16];
            valid_q  <= 1'b1;
            addr_q   <= addr_step_d;
            if (play) begin
              read_q  <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          read_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign flash_mem_read       = read_q;
  assign flash_mem_address    = addr_q;
  assign flash_mem_byteenable = FLASH_BYTEEN_ALL;
  assign sample_out           = sample_q;
  assign sample_valid         = valid_q;
  assign underrun_count       = underrun_q;
  assign busy                 = (state_q != IDLE);

endmodule
